// File: rtl/rv32i_mem_pkg.sv
// Shared types and constants for the rv32i unified memory-port arbiter.
package rv32i_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // Memory opcodes shared with the core's memory-access stage.
  localparam logic [1:0] MEM_OP_NONE  = 2'd0;
  localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
  localparam logic [1:0] MEM_OP_STORE = 2'd2;

endpackage

// File: rtl/rv32i_mem_arbiter_timeout_ctr.sv
// Response watchdog: counts cycles a transaction has been active, flags expiry on the last allowed cycle.
module rv32i_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                   cnt_d = '0;
    else if (en && LIMIT > 0)  cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // cnt_q holds cycles already spent; this cycle is the LIMIT-th one.
  generate
    if (LIMIT > 0) begin : g_on
      assign expire = en && (cnt_q == W'(LIMIT - 1));
    end else begin : g_off
      assign expire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto one word-wide memory port, one transaction in flight,
// D-over-IF priority with a fetch starvation guard and a response watchdog.
module rv32i_mem_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int XLEN               = 32,
  parameter int FETCH_STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYCLES     = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int SW = (FETCH_STARVE_LIMIT > 0) ? $clog2(FETCH_STARVE_LIMIT + 1) : 1;

  arb_state_e      state_q, state_d;
  logic            owner_q, owner_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic            if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic            if_err_q, if_err_d, d_err_q, d_err_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;

  logic gnt_if, gnt_d, starved, resp, done, fin_err, tmo_expire;

  assign starved = (streak_q == SW'(FETCH_STARVE_LIMIT));

  rv32i_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (gnt_if | gnt_d),
    .en     (state_q != ST_IDLE),
    .expire (tmo_expire)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_err_d    = 1'b0;
    d_err_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    gnt_if      = 1'b0;
    gnt_d       = 1'b0;
    resp        = 1'b0;
    done        = 1'b0;
    fin_err     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        gnt_d  = d_req && !(if_req && starved);
        gnt_if = if_req && !gnt_d;
        if (gnt_d) begin
          owner_d     = OWN_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          state_d     = ST_REQ;
          // D only wins against a pending fetch below the limit, so this never overflows.
          streak_d    = if_req ? streak_q + SW'(1) : '0;
        end else if (gnt_if) begin
          owner_d     = OWN_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          state_d     = ST_REQ;
          streak_d    = '0;
        end
      end
      ST_REQ, ST_WAIT: begin
        // A response beats a simultaneous watchdog expiry.
        resp = mem_rvalid && (state_q == ST_WAIT || mem_gnt);
        if (resp) begin
          done = 1'b1;
        end else if (tmo_expire) begin
          done    = 1'b1;
          fin_err = 1'b1;
        end else if (state_q == ST_REQ && mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (done) begin
      state_d   = ST_IDLE;
      mem_req_d = 1'b0;
      if (owner_q == OWN_D) begin
        d_rvalid_d = 1'b1;
        d_err_d    = fin_err;
        d_rdata_d  = fin_err ? '0 : mem_rdata;
      end else begin
        if_rvalid_d = 1'b1;
        if_err_d    = fin_err;
        if_rdata_d  = fin_err ? '0 : mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_err_q    <= if_err_d;
      d_err_q     <= d_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Grants are combinational; keep them quiet while reset is held.
  assign if_gnt    = gnt_if & ~rst;
  assign d_gnt     = gnt_d & ~rst;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/rv32i_mem_arbiter.md
Name: rv32i_mem_arbiter

Overview:
- Shares one unified word-wide memory port between two requesters: instruction fetch (IF) and data load/store (D).
- Allows at most one outstanding transaction.
- Fixed priority D > IF, with a starvation guard for IF and a response-timeout watchdog.
- Sits between the rv32i core's fetch and memory-access paths and the single external memory/bus slave.

Parameters:
- XLEN, 32, address/data width
- FETCH_STARVE_LIMIT, 4, consecutive D grants taken while IF is pending before IF is forced to win
- TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before a transaction is aborted with error; 0 disables the watchdog

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  XLEN  fetch word address
- if_gnt  out  1  fetch accepted (combinational, 1-cycle pulse)
- if_rvalid  out  1  fetch response pulse
- if_rdata  out  XLEN  fetched instruction
- if_err  out  1  fetch timed out (valid with if_rvalid)
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  XLEN  data word address
- d_wdata  in  XLEN  store data
- d_gnt  out  1  data accepted (combinational, 1-cycle pulse)
- d_rvalid  out  1  data response pulse (loads and stores)
- d_rdata  out  XLEN  load data
- d_err  out  1  data timed out (valid with d_rvalid)
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  XLEN  memory address, registered
- mem_wdata  out  XLEN  memory write data, registered
- mem_gnt  in  1  memory has accepted the request
- mem_rvalid  in  1  memory response pulse
- mem_rdata  in  XLEN  memory read data

Behaviour:
- Reset (asynchronous, active-high; mid-transaction included):
  - state = IDLE; every output = 0; owner, streak and timeout counters = 0.
  - Any in-flight transaction is discarded and produces no response.
- States:
  - IDLE: arbitrate among requests.
  - REQ: mem_req = 1 until mem_gnt.
  - WAIT: awaiting mem_rvalid.
- IDLE arbitration:
  - Only d_req: D wins.
  - Only if_req: IF wins.
  - Both asserted: D wins unless streak == FETCH_STARVE_LIMIT, in which case IF wins.
  - Winner's gnt = 1 in the same cycle. At the clock edge: latch owner, we (0 for IF), addr and wdata into the mem_* registers; go to REQ.
  - Requester may drop or change its req/fields from the cycle after gnt.
- Streak counter:
  - D grant with if_req high: streak += 1 (saturates at FETCH_STARVE_LIMIT).
  - Any IF grant, or D grant with if_req low: streak = 0.
- REQ: when mem_gnt = 1, mem_req drops at the edge and state goes to WAIT. mem_gnt with mem_rvalid in the same cycle goes directly to response, skipping WAIT.
- WAIT: on mem_rvalid, at the edge:
  - owner's rvalid = 1 for one cycle; rdata = mem_rdata captured; err = 0.
  - state → IDLE.
- Latency:
  - Grant cycle 0; mem_req high from cycle 1.
  - With zero-wait memory (mem_gnt in cycle 1, mem_rvalid in cycle 2), owner rvalid is in cycle 3.
  - A new grant may occur in the same cycle as rvalid (IDLE).
- Store responses: rvalid pulses; rdata carries captured mem_rdata, which is don't-care for the requester.
- Non-owner rvalid/err stay 0. rdata outputs hold their last captured value between responses.
- Timeout (TIMEOUT_CYCLES > 0):
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES without a response: owner rvalid = 1, err = 1, rdata = 0; mem_req = 0; state → IDLE.
  - Response takes precedence: mem_rvalid arriving in the same cycle as expiry completes normally (err = 0).
- mem_rvalid in IDLE (stray or late after timeout) is ignored; no output changes.
- A gnt is never issued outside IDLE. Requests arriving while busy wait, held by the requester.

Decomposition:
- Shared package rv32i_mem_pkg holds:
  - state encoding localparams (IDLE, REQ, WAIT)
  - owner ID constants (OWN_IF = 0, OWN_D = 1)
  - memory opcode constants reused by the core
- One natural sub-module: rv32i_timeout_ctr (clear/enable/expire, width $clog2(TIMEOUT_CYCLES+1)). Arbitration logic stays inline.

Test Plan:
- IF-only fetch, addr 0x00000010, mem_gnt immediate, mem_rvalid next cycle with 0x00A00093 → if_gnt cycle 0, mem_req cycle 1, if_rvalid cycle 3 with if_rdata = 0x00A00093, if_err = 0.
- Simultaneous if_req + d_req (store, addr 0x100, wdata 0xDEADBEEF) → d_gnt first; mem_we = 1, mem_wdata = 0xDEADBEEF; d_rvalid pulses; if_gnt issued in the same cycle as d_rvalid.
- if_req held continuously with d_req asserted every IDLE, FETCH_STARVE_LIMIT = 4 → exactly 4 D grants, then 1 IF grant, then the streak restarts.
- mem_gnt delayed 3 cycles, load from 0x200 returns 0x12345678 → mem_req/mem_addr stable for the 3 cycles; d_rdata = 0x12345678.
- TIMEOUT_CYCLES = 8, memory never responds → d_rvalid = 1, d_err = 1, d_rdata = 0 after 8 cycles in REQ/WAIT; late mem_rvalid afterwards produces no pulse.
- rst asserted while in WAIT → all outputs 0 immediately; after release, a pending if_req is granted in the first cycle.
